// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, dwell constants and sizing helpers for the keypad scanner
package keypad_pkg;

  // Dwell cycle on which the settled, synchronised rows are latched
  localparam int DWELL_CAPTURE   = 3;
  // First dwell cycle of per-row debounce processing (row 0)
  localparam int DWELL_PROC_BASE = 4;
  // Debounce counter width; DEBOUNCE is limited to 1..15
  localparam int CNT_W           = 4;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_t;

  // Index width for n items, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Key code width for a matrix of n_keys keys
  function automatic int code_w(input int n_keys);
    return idx_w(n_keys);
  endfunction

  // Event word layout: {press, code}; press sits at bit code_w(n_keys)
  function automatic int ev_w(input int n_keys);
    return code_w(n_keys) + 1;
  endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// rtl/kp_event_fifo.sv - event FIFO with valid/ready pop side and wrap-bit full detection
module kp_event_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_empty;
  logic         w_pop;
  logic         w_wr_en;

  // Extra pointer bit distinguishes full (lap ahead) from empty (same lap)
  assign w_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_valid = !w_empty;
  assign w_pop   = o_valid && i_ready;
  // A pop frees the head slot in the same edge, so a full FIFO can still accept
  assign w_wr_en = i_push && (!o_full || w_pop);
  // Outputs read as zero while empty so stale storage never shows
  assign o_data  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];

  // read/write pointers, wrapping modulo the depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)   r_rd <= r_rd + (AW+1)'(1);
    end
  end

  // event storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column-scanning keypad controller with per-key debounce and event queue
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int N_ROWS     = 4,
  parameter int N_COLS     = 4,
  parameter int SCAN_DIV   = 16,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_ROWS-1:0]                   rows,
  output logic [N_COLS-1:0]                   cols,
  output logic                                ev_valid,
  input  logic                                ev_ready,
  output logic                                ev_press,
  output logic [code_w(N_ROWS*N_COLS)-1:0]    ev_code,
  output logic [N_ROWS*N_COLS-1:0]            key_down,
  output logic                                overflow,
  input  logic                                ovf_clr
);
  localparam int N_KEYS = N_ROWS * N_COLS;
  localparam int CODE_W = code_w(N_KEYS);
  localparam int EV_W   = ev_w(N_KEYS);
  localparam int DW     = idx_w(SCAN_DIV);
  localparam int CW     = idx_w(N_COLS);
  localparam int RW     = idx_w(N_ROWS);

  scan_state_t       r_state;
  scan_state_t       w_state_nxt;
  logic [DW-1:0]     r_dwell;
  logic [DW-1:0]     w_dwell_nxt;
  logic [CW-1:0]     r_col;
  logic [CW-1:0]     w_col_nxt;
  logic              w_capture;
  logic              w_proc;

  logic [N_ROWS-1:0] r_sync1;
  logic [N_ROWS-1:0] r_sync2;
  logic [N_ROWS-1:0] r_cap;

  logic [N_KEYS-1:0] r_key_down;
  logic [CNT_W-1:0]  r_cnt [N_KEYS];
  logic [RW-1:0]     w_row;
  logic [CODE_W-1:0] w_key;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_differs;
  logic              w_push;

  logic              w_fifo_full;
  logic [EV_W-1:0]   w_ev_head;
  logic              r_ovf;

  // scan position register: idle in reset, then dwell counter and active column
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_dwell <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dwell <= w_dwell_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // next position: leaving idle lands on dwell 0 of column 0; otherwise dwell, then rotate
  always_comb begin
    w_state_nxt = ST_SCAN;
    w_dwell_nxt = '0;
    w_col_nxt   = '0;
    if (r_state == ST_SCAN) begin
      if (r_dwell == DW'(SCAN_DIV - 1)) begin
        w_col_nxt = (r_col == CW'(N_COLS - 1)) ? '0 : r_col + CW'(1);
      end else begin
        w_dwell_nxt = r_dwell + DW'(1);
        w_col_nxt   = r_col;
      end
    end
  end

  // column drive and the capture / per-row processing strobes within a dwell
  always_comb begin
    cols      = '0;
    w_capture = 1'b0;
    w_proc    = 1'b0;
    if (r_state == ST_SCAN) begin
      cols      = N_COLS'(1) << r_col;
      w_capture = (r_dwell == DW'(DWELL_CAPTURE));
      w_proc    = (32'(r_dwell) >= DWELL_PROC_BASE) &&
                  (32'(r_dwell) <  DWELL_PROC_BASE + N_ROWS);
    end
  end

  // two-stage synchroniser on the asynchronous row inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= rows;
      r_sync2 <= r_sync1;
    end
  end

  // hold the settled row pattern of the active column for row-by-row processing
  always_ff @(posedge clk) begin
    if (rst)            r_cap <= '0;
    else if (w_capture) r_cap <= r_sync2;
  end

  // one row per cycle, row 0 first; code = col * N_ROWS + row
  assign w_row     = RW'(r_dwell - DW'(DWELL_PROC_BASE));
  assign w_key     = CODE_W'(r_col) * CODE_W'(N_ROWS) + CODE_W'(w_row);
  assign w_differs = (r_cap[w_row] != r_key_down[w_key]);
  assign w_cnt_inc = r_cnt[w_key] + CNT_W'(1);
  assign w_push    = w_proc && w_differs && (w_cnt_inc == CNT_W'(DEBOUNCE));

  // per-key debounce: count disagreeing samples, toggle state on the DEBOUNCE-th
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_down <= '0;
      for (int k = 0; k < N_KEYS; k++) r_cnt[k] <= '0;
    end else if (w_proc) begin
      if (!w_differs) begin
        r_cnt[w_key] <= '0;
      end else if (w_push) begin
        r_key_down[w_key] <= ~r_key_down[w_key];
        r_cnt[w_key]      <= '0;
      end else begin
        r_cnt[w_key] <= w_cnt_inc;
      end
    end
  end

  kp_event_fifo #(
    .W     (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({~r_key_down[w_key], w_key}),
    .o_full  (w_fifo_full),
    .o_valid (ev_valid),
    .i_ready (ev_ready),
    .o_data  (w_ev_head)
  );

  // sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (rst)                                    r_ovf <= 1'b0;
    else if (w_push && w_fifo_full && !ev_ready) r_ovf <= 1'b1;
    else if (ovf_clr)                           r_ovf <= 1'b0;
  end

  assign ev_press = w_ev_head[CODE_W];
  assign ev_code  = w_ev_head[CODE_W-1:0];
  assign key_down = r_key_down;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic        ev_press;
  logic [3:0]  ev_code;
  logic [15:0] key_down;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  logic [15:0] tb_keys = '0;
  int          cyc;
  int          total = 0;
  int          bad = 0;

  keypad_scanner dut (
    .clk      (clk),
    .rst      (rst),
    .rows     (rows),
    .cols     (cols),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_press (ev_press),
    .ev_code  (ev_code),
    .key_down (key_down),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  // cycle index since reset release: 0 is the cycle after the first unreset edge
  always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

  // key matrix: a pressed key ties its column drive onto its row
  always_comb begin
    rows = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (cols[c] && tb_keys[c*4 + r]) rows[r] = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [15:0] keys);
    rst = 1'b1;
    ev_ready = 1'b0;
    ovf_clr = 1'b0;
    tb_keys = keys;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_one(output logic p, output logic [3:0] c, output bit ok);
    int n;
    n = 0;
    ok = 1'b0; p = 1'b0; c = '0;
    while (ev_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ev_valid === 1'b1) begin
      ok = 1'b1; p = ev_press; c = ev_code;
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tb_keys = 16'hFFFF;
    repeat (3) @(negedge clk);
    total++; if (cols !== 4'h0) begin bad++; $display("FAIL rst_cols: got %0h want 0", cols); end
    total++; if (key_down !== 16'h0) begin bad++; $display("FAIL rst_key_down: got %0h want 0", key_down); end
    total++; if ({ev_valid, ev_press, ev_code, overflow} !== 7'h0)
      begin bad++; $display("FAIL rst_outputs: got v=%0b p=%0b c=%0d o=%0b want all 0", ev_valid, ev_press, ev_code, overflow); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (cols !== 4'h1) begin bad++; $display("FAIL first_col: got %0h want 1", cols); end
    wait_cyc(15);
    total++; if (cols !== 4'h1) begin bad++; $display("FAIL dwell_end: got %0h want 1", cols); end
    wait_cyc(16);
    total++; if (cols !== 4'h2) begin bad++; $display("FAIL col1: got %0h want 2", cols); end
    wait_cyc(48);
    total++; if (cols !== 4'h8) begin bad++; $display("FAIL col3: got %0h want 8", cols); end
    wait_cyc(64);
    total++; if (cols !== 4'h1) begin bad++; $display("FAIL col_wrap: got %0h want 1", cols); end
  endtask

  task automatic test_single_key();
    logic p; logic [3:0] c; bit ok;
    do_reset(16'h0200);
    wait_cyc(229);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL single_early: got %0b want 0", ev_valid); end
    wait_cyc(230);
    total++; if ({ev_valid, ev_press, ev_code} !== {1'b1, 1'b1, 4'd9})
      begin bad++; $display("FAIL single_event: got v=%0b p=%0b c=%0d want 1 1 9", ev_valid, ev_press, ev_code); end
    total++; if (key_down !== 16'h0200) begin bad++; $display("FAIL single_down: got %0h want 0200", key_down); end
    wait_cyc(6*64);
    total++; if ({ev_valid, ev_press, ev_code} !== {1'b1, 1'b1, 4'd9})
      begin bad++; $display("FAIL single_hold: got v=%0b p=%0b c=%0d want 1 1 9", ev_valid, ev_press, ev_code); end
    pop_one(p, c, ok);
    total++; if (!ok || {p, c} !== {1'b1, 4'd9}) begin bad++; $display("FAIL single_pop: got ok=%0b p=%0b c=%0d want 1 9", ok, p, c); end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL single_count: got valid=%0b want 0", ev_valid); end
  endtask

  task automatic test_bounce();
    do_reset(16'h0020);
    wait_cyc(40);  tb_keys = 16'h0000;
    wait_cyc(104); tb_keys = 16'h0020;
    wait_cyc(168); tb_keys = 16'h0000;
    wait_cyc(8*64);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL bounce_event: got %0b want 0", ev_valid); end
    total++; if (key_down !== 16'h0) begin bad++; $display("FAIL bounce_down: got %0h want 0", key_down); end
  endtask

  task automatic test_rollover();
    logic p; logic [3:0] c; bit ok;
    logic       exp_p [4];
    logic [3:0] exp_c [4];
    exp_p = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_c = '{4'd0, 4'd15, 4'd0, 4'd15};
    do_reset(16'h8001);
    wait_cyc(250);
    total++; if (key_down !== 16'h8001) begin bad++; $display("FAIL nkro_down: got %0h want 8001", key_down); end
    tb_keys = 16'h0000;
    wait_cyc(520);
    total++; if (key_down !== 16'h0) begin bad++; $display("FAIL nkro_up: got %0h want 0", key_down); end
    for (int i = 0; i < 4; i++) begin
      pop_one(p, c, ok);
      total++; if (!ok || {p, c} !== {exp_p[i], exp_c[i]})
        begin bad++; $display("FAIL nkro_ev%0d: got ok=%0b p=%0b c=%0d want p=%0b c=%0d", i, ok, p, c, exp_p[i], exp_c[i]); end
    end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL nkro_extra: got %0b want 0", ev_valid); end
  endtask

  task automatic test_overflow();
    logic p; logic [3:0] c; bit ok;
    do_reset(16'h01FF);
    wait_cyc(228);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before: got %0b want 0", overflow); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_drop_vs_clr: got %0b want 1", overflow); end
    total++; if (key_down !== 16'h01FF) begin bad++; $display("FAIL ovf_down: got %0h want 01ff", key_down); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %0b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      pop_one(p, c, ok);
      total++; if (!ok || {p, c} !== {1'b1, 4'(i)})
        begin bad++; $display("FAIL ovf_drain%0d: got ok=%0b p=%0b c=%0d want p=1 c=%0d", i, ok, p, c, i); end
    end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL ovf_extra: got %0b want 0", ev_valid); end
  endtask

  task automatic test_full_push_pop();
    logic p; logic [3:0] c; bit ok;
    do_reset(16'h00FF);
    wait_cyc(40);
    tb_keys = 16'h01FF;
    wait_cyc(292);
    total++; if ({ev_valid, ev_code} !== {1'b1, 4'd0})
      begin bad++; $display("FAIL fpp_head: got v=%0b c=%0d want 1 0", ev_valid, ev_code); end
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf: got %0b want 0", overflow); end
    total++; if (key_down !== 16'h01FF) begin bad++; $display("FAIL fpp_down: got %0h want 01ff", key_down); end
    for (int i = 1; i <= 8; i++) begin
      pop_one(p, c, ok);
      total++; if (!ok || {p, c} !== {1'b1, 4'(i)})
        begin bad++; $display("FAIL fpp_drain%0d: got ok=%0b p=%0b c=%0d want p=1 c=%0d", i, ok, p, c, i); end
    end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL fpp_extra: got %0b want 0", ev_valid); end
  endtask

  task automatic test_reset_midop();
    do_reset(16'h0018);
    wait_cyc(220);
    total++; if ({ev_valid, ev_code} !== {1'b1, 4'd3})
      begin bad++; $display("FAIL mid_queued: got v=%0b c=%0d want 1 3", ev_valid, ev_code); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({ev_valid, key_down, cols, overflow} !== 22'h0)
      begin bad++; $display("FAIL mid_rst: got v=%0b down=%0h cols=%0h o=%0b want all 0", ev_valid, key_down, cols, overflow); end
    tb_keys = 16'h0008;
    rst = 1'b0;
    @(negedge clk);
    total++; if (cols !== 4'h1) begin bad++; $display("FAIL mid_cols: got %0h want 1", cols); end
    wait_cyc(199);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL mid_no_release: got %0b want 0", ev_valid); end
    wait_cyc(200);
    total++; if ({ev_valid, ev_press, ev_code} !== {1'b1, 1'b1, 4'd3})
      begin bad++; $display("FAIL mid_repress: got v=%0b p=%0b c=%0d want 1 1 3", ev_valid, ev_press, ev_code); end
    total++; if (key_down !== 16'h0008) begin bad++; $display("FAIL mid_down: got %0h want 0008", key_down); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_rollover();
    test_overflow();
    test_full_push_pop();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
